// File: rtl/fifo_pkt_reader.sv
// fifo_pkt_reader: pops FWFT FIFO words, parses {dest,len} headers, streams packets with sop/eop.
// Ports: clk/rst (sync, active-high); rempty/rdata/rinc FIFO read side;
// out_valid/out_ready/out_data/out_sop/out_eop output stream;
// pkt_dest last header dest; busy mid-packet; pkt_cnt packets fully popped.
module fifo_pkt_reader #(
  parameter int DATA_W = 8,
  parameter int DEST_W = 2,
  parameter int LEN_W  = 6,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rempty,
  input  logic [DATA_W-1:0] rdata,
  output logic              rinc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic [DEST_W-1:0] pkt_dest,
  output logic              busy,
  output logic [CNT_W-1:0]  pkt_cnt
);
  typedef enum logic {IDLE, PAY} state_t;
  state_t r_state, w_state_n;
  logic [LEN_W-1:0] r_rem, w_rem_n;
  logic [LEN_W-1:0] w_len;
  logic w_last;
  assign w_len = rdata[LEN_W-1:0];
  // rst gates rinc so the FIFO is never popped while held in reset
  assign rinc = !rst && !rempty && (!out_valid || out_ready);
  assign busy = r_state != IDLE;
  always_comb begin
    w_state_n = r_state;
    w_rem_n = r_rem;
    w_last = 1'b0;
    if (rinc) begin
      w_last = r_state == IDLE ? w_len == '0 : r_rem == LEN_W'(1);
      w_rem_n = r_state == IDLE ? w_len : r_rem - 1'b1;
      w_state_n = w_last ? IDLE : PAY;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rem <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_sop <= 1'b0;
      out_eop <= 1'b0;
      pkt_dest <= '0;
      pkt_cnt <= '0;
    end else begin
      r_state <= w_state_n;
      r_rem <= w_rem_n;
      if (rinc) begin
        out_valid <= 1'b1;
        out_data <= rdata;
        out_sop <= r_state == IDLE;
        out_eop <= w_last;
        if (r_state == IDLE) pkt_dest <= rdata[DATA_W-1 -: DEST_W];
        if (w_last) pkt_cnt <= pkt_cnt + 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule
